// File: rtl/avmm_pkg.sv
// Shared definitions for the Avalon-MM command master: FSM state encoding
// and the data word returned when a transaction is abandoned.
package avmm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUS,
      ST_RDWAIT,
      ST_RSP
   } avmm_state_e;

   localparam logic [31:0] TIMEOUT_PATTERN = 32'hdeadbeef;

endpackage

// File: rtl/avmm_cmd_master.sv
// Turns one streamed command at a time into a single Avalon-MM read or write,
// then returns one response word (read data, zero, or a timeout marker).
module avmm_cmd_master
   import avmm_pkg::*;
#(
   parameter int ADDR_W       = 9,
   parameter int READ_LATENCY = 1,
   parameter int TIMEOUT      = 255
) (
   input  logic              csi_clk_clk,
   input  logic              rsi_reset_reset_n,
   input  logic              asi_cmd_valid,
   output logic              asi_cmd_ready,
   input  logic              asi_cmd_write,
   input  logic [ADDR_W-1:0] asi_cmd_address,
   input  logic [31:0]       asi_cmd_writedata,
   output logic [ADDR_W-1:0] avm_ctrl_address,
   output logic              avm_ctrl_read,
   output logic              avm_ctrl_write,
   output logic [31:0]       avm_ctrl_writedata,
   input  logic [31:0]       avm_ctrl_readdata,
   input  logic              avm_ctrl_waitrequest,
   output logic              aso_rsp_valid,
   input  logic              aso_rsp_ready,
   output logic [31:0]       aso_rsp_data,
   output logic              aso_rsp_error,
   output logic [15:0]       coe_timeout_count
);

   // A timeout fires on the TIMEOUT-th stalled edge, so compare against TIMEOUT-1
   // before the counter is bumped.
   localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT - 1);
   localparam logic [2:0]  LAT_LIMIT   = 3'(READ_LATENCY);

   avmm_state_e state;
   logic [15:0] stall_cnt;
   logic [2:0]  lat_cnt;

   // Single registered FSM; the strobes themselves remember read vs write while in BUS.
   always_ff @(posedge csi_clk_clk or negedge rsi_reset_reset_n) begin
      if (!rsi_reset_reset_n) begin
         state              <= ST_IDLE;
         asi_cmd_ready      <= 1'b0;
         avm_ctrl_address   <= '0;
         avm_ctrl_read      <= 1'b0;
         avm_ctrl_write     <= 1'b0;
         avm_ctrl_writedata <= '0;
         aso_rsp_valid      <= 1'b0;
         aso_rsp_data       <= '0;
         aso_rsp_error      <= 1'b0;
         coe_timeout_count  <= '0;
         stall_cnt          <= '0;
         lat_cnt            <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (asi_cmd_valid && asi_cmd_ready) begin
                  avm_ctrl_address   <= asi_cmd_address;
                  avm_ctrl_writedata <= asi_cmd_writedata;
                  avm_ctrl_read      <= !asi_cmd_write;
                  avm_ctrl_write     <= asi_cmd_write;
                  asi_cmd_ready      <= 1'b0;
                  stall_cnt          <= '0;
                  state              <= ST_BUS;
               end else begin
                  asi_cmd_ready <= 1'b1;
               end
            end
            ST_BUS: begin
               if (!avm_ctrl_waitrequest) begin
                  avm_ctrl_read  <= 1'b0;
                  avm_ctrl_write <= 1'b0;
                  if (avm_ctrl_read) begin
                     lat_cnt <= 3'd1;
                     state   <= ST_RDWAIT;
                  end else begin
                     aso_rsp_data  <= '0;
                     aso_rsp_error <= 1'b0;
                     aso_rsp_valid <= 1'b1;
                     state         <= ST_RSP;
                  end
               end else if (stall_cnt == STALL_LIMIT) begin
                  avm_ctrl_read  <= 1'b0;
                  avm_ctrl_write <= 1'b0;
                  aso_rsp_data   <= TIMEOUT_PATTERN;
                  aso_rsp_error  <= 1'b1;
                  aso_rsp_valid  <= 1'b1;
                  if (coe_timeout_count != 16'hffff) begin
                     coe_timeout_count <= coe_timeout_count + 16'd1;
                  end
                  state <= ST_RSP;
               end else begin
                  stall_cnt <= stall_cnt + 16'd1;
               end
            end
            ST_RDWAIT: begin
               if (lat_cnt == LAT_LIMIT) begin
                  aso_rsp_data  <= avm_ctrl_readdata;
                  aso_rsp_error <= 1'b0;
                  aso_rsp_valid <= 1'b1;
                  state         <= ST_RSP;
               end else begin
                  lat_cnt <= lat_cnt + 3'd1;
               end
            end
            ST_RSP: begin
               if (aso_rsp_ready) begin
                  aso_rsp_valid <= 1'b0;
                  asi_cmd_ready <= 1'b1;
                  state         <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_avmm_cmd_master.sv
// Randomized bench for avmm_cmd_master: a simple Avalon-MM slave plus a
// transaction-level model predicting each response, its timing and strobe length.
module tb_avmm_cmd_master;

   localparam int ADDR_W       = 9;
   localparam int READ_LATENCY = 1;
   localparam int TIMEOUT      = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              asi_cmd_valid = 1'b0;
   logic              asi_cmd_ready;
   logic              asi_cmd_write = 1'b0;
   logic [ADDR_W-1:0] asi_cmd_address = '0;
   logic [31:0]       asi_cmd_writedata = '0;
   logic [ADDR_W-1:0] avm_ctrl_address;
   logic              avm_ctrl_read;
   logic              avm_ctrl_write;
   logic [31:0]       avm_ctrl_writedata;
   logic [31:0]       avm_ctrl_readdata = '0;
   logic              avm_ctrl_waitrequest;
   logic              aso_rsp_valid;
   logic              aso_rsp_ready = 1'b0;
   logic [31:0]       aso_rsp_data;
   logic              aso_rsp_error;
   logic [15:0]       coe_timeout_count;

   int compare_count  = 0;
   int mismatch_count = 0;

   // Slave environment state
   int          stall_target = 0;
   int          strobe_run = 0;
   int          strobe_total = 0;
   int          wr_accept_total = 0;
   int          both_total = 0;
   logic [31:0] last_wdata = '0;
   bit          written [512];
   bit   [31:0] wmem [512];

   // Transaction-level reference model
   logic [31:0] ref_mem [logic [ADDR_W-1:0]];
   logic [15:0] exp_to = '0;

   always #5 clk = ~clk;

   avmm_cmd_master #(
      .ADDR_W(ADDR_W),
      .READ_LATENCY(READ_LATENCY),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .csi_clk_clk(clk),
      .rsi_reset_reset_n(rst_n),
      .asi_cmd_valid(asi_cmd_valid),
      .asi_cmd_ready(asi_cmd_ready),
      .asi_cmd_write(asi_cmd_write),
      .asi_cmd_address(asi_cmd_address),
      .asi_cmd_writedata(asi_cmd_writedata),
      .avm_ctrl_address(avm_ctrl_address),
      .avm_ctrl_read(avm_ctrl_read),
      .avm_ctrl_write(avm_ctrl_write),
      .avm_ctrl_writedata(avm_ctrl_writedata),
      .avm_ctrl_readdata(avm_ctrl_readdata),
      .avm_ctrl_waitrequest(avm_ctrl_waitrequest),
      .aso_rsp_valid(aso_rsp_valid),
      .aso_rsp_ready(aso_rsp_ready),
      .aso_rsp_data(aso_rsp_data),
      .aso_rsp_error(aso_rsp_error),
      .coe_timeout_count(coe_timeout_count)
   );

   function automatic logic [31:0] init_val(input logic [ADDR_W-1:0] a);
      if (a == '0) return 32'hc10cc272;
      return {23'h0, a} * 32'h9e3779b1 + 32'h1234;
   endfunction

   function automatic logic [31:0] mem_value(input logic [ADDR_W-1:0] a);
      return written[a] ? wmem[a] : init_val(a);
   endfunction

   // The slave stalls the first stall_target cycles of each strobe burst;
   // outside an accepted read it drives junk so a mistimed capture shows up.
   assign avm_ctrl_waitrequest = (strobe_run < stall_target);

   always @(posedge clk) begin
      strobe_run   <= (avm_ctrl_read || avm_ctrl_write) ? strobe_run + 1 : 0;
      strobe_total <= strobe_total + ((avm_ctrl_read || avm_ctrl_write) ? 1 : 0);
      both_total   <= both_total + ((avm_ctrl_read && avm_ctrl_write) ? 1 : 0);
      if (avm_ctrl_write && !avm_ctrl_waitrequest) begin
         wmem[avm_ctrl_address]    <= avm_ctrl_writedata;
         written[avm_ctrl_address] <= 1'b1;
         wr_accept_total           <= wr_accept_total + 1;
         last_wdata                <= avm_ctrl_writedata;
      end
      avm_ctrl_readdata <= (avm_ctrl_read && !avm_ctrl_waitrequest) ?
                           mem_value(avm_ctrl_address) : $urandom();
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      compare_count++;
      if (actual !== expected) begin
         mismatch_count++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   task automatic scrambleCmd();
      asi_cmd_write     = 1'($urandom());
      asi_cmd_address   = ADDR_W'($urandom());
      asi_cmd_writedata = $urandom();
   endtask

   // One complete command: model prediction, issue, timing, response and side-effect checks.
   task automatic applyStimulus(input logic wr, input logic [ADDR_W-1:0] addr,
                                input logic [31:0] wdata, input int stalls, input int hold);
      int n;
      int strobe_before;
      int wr_before;
      int exp_n;
      int exp_strobes;
      bit timed_out;
      logic [31:0] exp_data;
      logic [31:0] held_data;
      logic exp_err;

      timed_out = (stalls >= TIMEOUT);
      if (timed_out) begin
         exp_data    = 32'hdeadbeef;
         exp_err     = 1'b1;
         exp_strobes = TIMEOUT;
         exp_n       = TIMEOUT + 1;
         if (exp_to != 16'hffff) exp_to = exp_to + 16'd1;
      end else begin
         exp_err     = 1'b0;
         exp_strobes = stalls + 1;
         exp_n       = stalls + 2 + (wr ? 0 : READ_LATENCY);
         if (wr) begin
            ref_mem[addr] = wdata;
            exp_data      = '0;
         end else begin
            exp_data = ref_mem.exists(addr) ? ref_mem[addr] : init_val(addr);
         end
      end

      @(negedge clk);
      stall_target      = stalls;
      aso_rsp_ready     = 1'b0;
      strobe_before     = strobe_total;
      wr_before         = wr_accept_total;
      asi_cmd_valid     = 1'b1;
      asi_cmd_write     = wr;
      asi_cmd_address   = addr;
      asi_cmd_writedata = wdata;
      n = 0;
      while (!asi_cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!asi_cmd_ready) begin
         asi_cmd_valid = 1'b0;
         checkOutput("cmd_accept", 32'(asi_cmd_ready), 32'd1);
         return;
      end

      // n counts negedges since the accepting clock edge.
      @(negedge clk);
      asi_cmd_valid = 1'b0;
      scrambleCmd();
      n = 1;
      while (!aso_rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
         scrambleCmd();
      end
      checkOutput("rsp_arrival", 32'(n), 32'(exp_n));
      if (!aso_rsp_valid) return;

      held_data = aso_rsp_data;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checkOutput("hold_valid", 32'(aso_rsp_valid), 32'd1);
         checkOutput("hold_data", aso_rsp_data, held_data);
         checkOutput("hold_cmd_ready", 32'(asi_cmd_ready), 32'd0);
         checkOutput("hold_no_strobe", 32'(avm_ctrl_read || avm_ctrl_write), 32'd0);
      end

      checkOutput("rsp_data", aso_rsp_data, exp_data);
      checkOutput("rsp_error", 32'(aso_rsp_error), 32'(exp_err));
      checkOutput("strobe_cycles", 32'(strobe_total - strobe_before), 32'(exp_strobes));
      checkOutput("write_accepts", 32'(wr_accept_total - wr_before), (wr && !timed_out) ? 32'd1 : 32'd0);
      if (wr && !timed_out) checkOutput("written_data", last_wdata, wdata);
      checkOutput("timeout_count", 32'(coe_timeout_count), 32'(exp_to));

      aso_rsp_ready = 1'b1;
      @(negedge clk);
      aso_rsp_ready = 1'b0;
      checkOutput("rsp_consumed", 32'(aso_rsp_valid), 32'd0);
      checkOutput("ready_after_rsp", 32'(asi_cmd_ready), 32'd1);
   endtask

   // Reset in the middle of a stalled read: strobe must drop asynchronously
   // and nothing from the abandoned read may surface afterwards.
   task automatic applyResetMidRead(input logic [ADDR_W-1:0] addr);
      int n;
      @(negedge clk);
      stall_target      = 100;
      asi_cmd_valid     = 1'b1;
      asi_cmd_write     = 1'b0;
      asi_cmd_address   = addr;
      n = 0;
      while (!asi_cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      asi_cmd_valid = 1'b0;
      @(negedge clk);
      checkOutput("pre_reset_read", 32'(avm_ctrl_read), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("reset_read_drop", 32'(avm_ctrl_read), 32'd0);
      checkOutput("reset_cmd_ready", 32'(asi_cmd_ready), 32'd0);
      checkOutput("reset_rsp_valid", 32'(aso_rsp_valid), 32'd0);
      checkOutput("reset_to_count", 32'(coe_timeout_count), 32'd0);
      exp_to = '0;
      stall_target = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("ready_after_release", 32'(asi_cmd_ready), 32'd1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checkOutput("no_rsp_after_reset", 32'(aso_rsp_valid), 32'd0);
      end
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int r;
      int stalls;
      repeat (3) @(negedge clk);
      checkOutput("rst_cmd_ready", 32'(asi_cmd_ready), 32'd0);
      checkOutput("rst_read", 32'(avm_ctrl_read), 32'd0);
      checkOutput("rst_write", 32'(avm_ctrl_write), 32'd0);
      checkOutput("rst_rsp_valid", 32'(aso_rsp_valid), 32'd0);
      checkOutput("rst_rsp_data", aso_rsp_data, 32'd0);
      checkOutput("rst_rsp_error", 32'(aso_rsp_error), 32'd0);
      checkOutput("rst_address", 32'(avm_ctrl_address), 32'd0);
      checkOutput("rst_writedata", avm_ctrl_writedata, 32'd0);
      checkOutput("rst_to_count", 32'(coe_timeout_count), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("first_ready", 32'(asi_cmd_ready), 32'd1);

      $display("[TB] directed transactions");
      applyStimulus(1'b0, 9'd0, 32'h0, 0, 0);
      applyStimulus(1'b1, 9'd3, 32'h12345678, 0, 0);
      applyStimulus(1'b0, 9'd3, 32'h0, 0, 0);
      applyStimulus(1'b1, 9'd5, 32'hcafef00d, 5, 0);
      applyStimulus(1'b1, 9'd6, 32'h0badf00d, 1000, 0);
      applyStimulus(1'b0, 9'd6, 32'h0, 0, 0);
      applyStimulus(1'b0, 9'd5, 32'h0, TIMEOUT - 1, 0);
      applyStimulus(1'b0, 9'd5, 32'h0, TIMEOUT, 0);
      applyStimulus(1'b0, 9'd3, 32'h0, 0, 10);

      $display("[TB] random transactions");
      for (int k = 0; k < 40; k++) begin
         r = $urandom_range(0, 9);
         if (r < 5)       stalls = 0;
         else if (r < 7)  stalls = $urandom_range(1, 3);
         else if (r == 7) stalls = TIMEOUT - 1;
         else if (r == 8) stalls = TIMEOUT;
         else             stalls = TIMEOUT + 3;
         applyStimulus(1'($urandom()), 9'($urandom_range(0, 7)), $urandom(),
                       stalls, $urandom_range(0, 3));
      end

      $display("[TB] reset during read");
      applyResetMidRead(9'd2);
      applyStimulus(1'b0, 9'd0, 32'h0, 0, 0);
      checkOutput("no_dual_strobe", 32'(both_total), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
      $finish;
   end

endmodule
